// File: rtl/btn_pkg.sv
// Shared constants and types for the reaction-game button front end.
// Default timing values are in 20 Hz control-clock cycles.
package btn_pkg;

    localparam int DEBOUNCE_TICKS = 2;
    localparam int REPEAT_DELAY   = 10;
    localparam int REPEAT_PERIOD  = 4;
    localparam int LONG_PRESS     = 40;

    function automatic int hold_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHORT = 2'd1,
        S_LONG  = 2'd2
    } s_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus consecutive-sample debounce filter for one button.
// press_nxt/release_nxt flag the cycle before the edge on which level flips.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int TICKS = btn_pkg::DEBOUNCE_TICKS
) (
    input  logic clk_20Hz,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_nxt,
    output logic release_nxt
);

    localparam int CNT_W = $clog2(TICKS + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(TICKS - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_20Hz or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Events are registered by the parent so pulses line up with the level flip.
    assign level       = level_q;
    assign press_nxt   = ~level_q & level_d;
    assign release_nxt = level_q & ~level_d;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced levels plus press/repeat/select/long-press pulses for three buttons.
// Macro BTN_AUTOREPEAT_EN adds up/down auto-repeat while held.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = btn_pkg::DEBOUNCE_TICKS,
    parameter int LONG_PRESS     = btn_pkg::LONG_PRESS
) (
    input  logic clk_20Hz,
    input  logic rst,
    input  logic btnU_raw,
    input  logic btnD_raw,
    input  logic btnS_raw,
    output logic btnU,
    output logic btnD,
    output logic btnS,
    output logic up_pulse,
    output logic down_pulse,
    output logic sel_pulse,
    output logic game_rst_req
);

    localparam int HW = hold_width(LONG_PRESS, REPEAT_DELAY);

    logic [2:0] lvl, press_nxt, rel_nxt;
    logic       up_raw, dn_raw;

    btn_debounce #(.TICKS(DEBOUNCE_TICKS)) u_deb_u (
        .clk_20Hz(clk_20Hz), .rst(rst), .raw(btnU_raw),
        .level(lvl[0]), .press_nxt(press_nxt[0]), .release_nxt(rel_nxt[0])
    );
    btn_debounce #(.TICKS(DEBOUNCE_TICKS)) u_deb_d (
        .clk_20Hz(clk_20Hz), .rst(rst), .raw(btnD_raw),
        .level(lvl[1]), .press_nxt(press_nxt[1]), .release_nxt(rel_nxt[1])
    );
    btn_debounce #(.TICKS(DEBOUNCE_TICKS)) u_deb_s (
        .clk_20Hz(clk_20Hz), .rst(rst), .raw(btnS_raw),
        .level(lvl[2]), .press_nxt(press_nxt[2]), .release_nxt(rel_nxt[2])
    );

`ifdef BTN_AUTOREPEAT_EN
    // Countdown to the next repeat; reloaded on press, never underflows.
    logic [HW-1:0] rep_q [2];
    logic [HW-1:0] rep_d [2];
    logic [1:0]    rep_fire;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_d[i]    = rep_q[i];
            rep_fire[i] = 1'b0;
            if (press_nxt[i]) begin
                rep_d[i] = HW'(REPEAT_DELAY - 1);
            end else if (lvl[i] && !rel_nxt[i]) begin
                if (rep_q[i] == '0) begin
                    rep_fire[i] = 1'b1;
                    rep_d[i]    = HW'(REPEAT_PERIOD - 1);
                end else begin
                    rep_d[i] = rep_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_20Hz or posedge rst) begin
        if (rst) begin
            rep_q[0] <= '0;
            rep_q[1] <= '0;
        end else begin
            rep_q[0] <= rep_d[0];
            rep_q[1] <= rep_d[1];
        end
    end

    assign up_raw = press_nxt[0] | rep_fire[0];
    assign dn_raw = press_nxt[1] | rep_fire[1];
`else
    logic unused_rel;
    assign unused_rel = ^rel_nxt[1:0];
    assign up_raw     = press_nxt[0];
    assign dn_raw     = press_nxt[1];
`endif

    s_state_e      state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          up_pulse_q, up_pulse_d;
    logic          down_pulse_q, down_pulse_d;
    logic          sel_pulse_q, sel_pulse_d;
    logic          game_rst_req_q, game_rst_req_d;

    always_comb begin
        state_d        = state_q;
        hold_d         = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        sel_pulse_d    = 1'b0;
        game_rst_req_d = 1'b0;
        // Opposing directions in the same cycle cancel each other.
        up_pulse_d     = up_raw & ~dn_raw;
        down_pulse_d   = dn_raw & ~up_raw;
        case (state_q)
            S_IDLE: begin
                hold_d = '0;
                if (press_nxt[2]) state_d = S_SHORT;
            end
            S_SHORT: begin
                if (rel_nxt[2]) begin
                    sel_pulse_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (hold_q == HW'(LONG_PRESS - 1)) begin
                    game_rst_req_d = 1'b1;
                    state_d        = S_LONG;
                end
            end
            S_LONG: begin
                if (rel_nxt[2]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_20Hz or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            hold_q         <= '0;
            up_pulse_q     <= 1'b0;
            down_pulse_q   <= 1'b0;
            sel_pulse_q    <= 1'b0;
            game_rst_req_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            up_pulse_q     <= up_pulse_d;
            down_pulse_q   <= down_pulse_d;
            sel_pulse_q    <= sel_pulse_d;
            game_rst_req_q <= game_rst_req_d;
        end
    end

    assign btnU         = lvl[0];
    assign btnD         = lvl[1];
    assign btnS         = lvl[2];
    assign up_pulse     = up_pulse_q;
    assign down_pulse   = down_pulse_q;
    assign sel_pulse    = sel_pulse_q;
    assign game_rst_req = game_rst_req_q;

endmodule
